// File: rtl/shift_sched_if.sv
// Client and shift-register-datapath signals of the two-requester shift scheduler.
// master = client/datapath side, slave = scheduler side.
interface shift_sched_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             fill0;
  logic             fill1;
  logic             ack0;
  logic             ack1;
  logic             sr_load;
  logic [WIDTH-1:0] sr_data;
  logic             sr_inp;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [CNT_W-1:0] shift_cnt;

  modport master (
    output req0, req1, data0, data1, fill0, fill1,
    input  ack0, ack1, sr_load, sr_data, sr_inp, busy, done, done_id, shift_cnt
  );

  modport slave (
    input  req0, req1, data0, data1, fill0, fill1,
    output ack0, ack1, sr_load, sr_data, sr_inp, busy, done, done_id, shift_cnt
  );
endinterface

// File: rtl/shift_sched.sv
// Round-robin load-then-shift scheduler for one shared WIDTH-bit shift register; WIDTH+2 busy cycles per job.
// Define SHIFT_SCHED_FIXED_PRIO_EN for fixed priority (req0 always wins); requests wait (level-held) until ack.
module shift_sched #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input logic          clk,
  input logic          rst,
  shift_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t state;
  logic   gid;
  logic   fill_q;
  logic   win;
  logic   any_req;

`ifdef SHIFT_SCHED_FIXED_PRIO_EN
  always_comb begin
    any_req = bus.req0 | bus.req1;
    win     = ~bus.req0;
  end
`else
  logic last_grant;

  always_comb begin
    any_req = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) win = ~last_grant;
    else                      win = ~bus.req0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      gid           <= 1'b0;
      fill_q        <= 1'b0;
`ifndef SHIFT_SCHED_FIXED_PRIO_EN
      last_grant    <= 1'b1;
`endif
      bus.ack0      <= 1'b0;
      bus.ack1      <= 1'b0;
      bus.sr_load   <= 1'b0;
      bus.sr_data   <= '0;
      bus.sr_inp    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.done_id   <= 1'b0;
      bus.shift_cnt <= '0;
    end else begin
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.done   <= 1'b0;
      bus.sr_inp <= 1'b0;
      case (state)
        IDLE: begin
          bus.sr_load   <= 1'b0;
          bus.busy      <= 1'b0;
          bus.shift_cnt <= '0;
          if (any_req) begin
            // Word and fill bit are captured here so later input changes cannot leak in.
            state       <= LOAD;
            gid         <= win;
`ifndef SHIFT_SCHED_FIXED_PRIO_EN
            last_grant  <= win;
`endif
            bus.sr_data <= win ? bus.data1 : bus.data0;
            fill_q      <= win ? bus.fill1 : bus.fill0;
            bus.ack0    <= ~win;
            bus.ack1    <= win;
            bus.sr_load <= 1'b1;
            bus.busy    <= 1'b1;
          end
        end
        LOAD: begin
          state         <= SHIFT;
          bus.sr_load   <= 1'b0;
          bus.sr_inp    <= fill_q;
          bus.shift_cnt <= '0;
        end
        SHIFT: begin
          if (bus.shift_cnt == CNT_W'(WIDTH - 1)) begin
            state         <= DONE;
            bus.done      <= 1'b1;
            bus.done_id   <= gid;
            bus.shift_cnt <= CNT_W'(WIDTH);
          end else begin
            bus.sr_inp    <= fill_q;
            bus.shift_cnt <= bus.shift_cnt + 1'b1;
          end
        end
        DONE: begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.done_id   <= 1'b0;
          bus.shift_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sched.sv
// Bench for shift_sched: transaction-level reference model driven by randomized level-held requesters.
module tb_shift_sched;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_sched_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: position of the current job in its fixed 6-cycle window (-1 = idle).
  int         ph      = -1;
  bit         m_gid   = 1'b0;
  bit         m_last  = 1'b1;
  logic [3:0] m_data  = '0;
  bit         m_fill  = 1'b0;
  bit         was_rst = 1'b0;
  int         m_done_n = 0;
  int         d_done_n = 0;
  int         last_ack_cyc = -1;
  int         cyc = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step();
    bit w;
    was_rst = rst;
    if (rst) begin
      ph     = -1;
      m_last = 1'b1;
      m_data = '0;
      m_fill = 1'b0;
    end else if (ph >= 0 && ph < WIDTH + 1) begin
      ph++;
    end else if (ph == WIDTH + 1) begin
      ph = -1;
    end else if (bus.req0 || bus.req1) begin
`ifdef SHIFT_SCHED_FIXED_PRIO_EN
      w = bus.req0 ? 1'b0 : 1'b1;
`else
      if (bus.req0 && bus.req1) w = ~m_last;
      else                      w = bus.req0 ? 1'b0 : 1'b1;
`endif
      m_last = w;
      m_gid  = w;
      m_data = w ? bus.data1 : bus.data0;
      m_fill = w ? bus.fill1 : bus.fill0;
      ph     = 0;
    end
  endtask

  task automatic check_outputs();
    bit shifting;
    int exp_cnt;
    shifting = (ph >= 1 && ph <= WIDTH);
    chk("busy",    bus.busy,    int'(ph >= 0));
    chk("ack0",    bus.ack0,    int'(ph == 0 && m_gid == 1'b0));
    chk("ack1",    bus.ack1,    int'(ph == 0 && m_gid == 1'b1));
    chk("sr_load", bus.sr_load, int'(ph == 0));
    chk("sr_inp",  bus.sr_inp,  shifting ? int'(m_fill) : 0);
    chk("done",    bus.done,    int'(ph == WIDTH + 1));
    chk("sr_data", bus.sr_data, int'(m_data));
    if (ph == WIDTH + 1) begin
      chk("done_id", bus.done_id, int'(m_gid));
      m_done_n++;
    end
    if (bus.done) d_done_n++;
    if (was_rst && ph < 0) begin
      chk("rst_cnt",  bus.shift_cnt, 0);
      chk("rst_did",  bus.done_id,   0);
    end else if (ph >= 1) begin
      exp_cnt = (ph == WIDTH + 1) ? WIDTH : ph - 1;
      chk("shift_cnt", bus.shift_cnt, exp_cnt);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check_outputs();
  endtask

  initial begin
    bus.req0  = 1'b1;
    bus.req1  = 1'b0;
    bus.data0 = 4'b1011;
    bus.data1 = 4'b0110;
    bus.fill0 = 1'b1;
    bus.fill1 = 1'b0;
    rst = 1'b1;

    // Reset held with req0 pending, then a lone request.
    repeat (2) cycle();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (bus.ack0) begin
        bus.req0  = 1'b0;
        bus.data0 = 4'b0000;
      end
    end

    // Contention: both held continuously; acks must be 7 cycles apart.
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    bus.data0 = 4'b1011;
    bus.data1 = 4'b0110;
    bus.fill1 = 1'b1;
    last_ack_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (bus.ack0 || bus.ack1) begin
        if (last_ack_cyc >= 0) chk("ack_spacing", cyc - last_ack_cyc, WIDTH + 3);
        last_ack_cyc = cyc;
      end
    end

    // Randomized clients, data changed right after accept, occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 79) == 0) || (ph == 3 && $urandom_range(0, 5) == 0);
      cycle();
      if (bus.ack0) begin
        bus.data0 = 4'($urandom);
        bus.fill0 = 1'($urandom);
        bus.req0  = 1'($urandom);
      end else if (!bus.req0) begin
        bus.data0 = 4'($urandom);
        bus.fill0 = 1'($urandom);
        bus.req0  = ($urandom_range(0, 3) == 0);
      end
      if (bus.ack1) begin
        bus.data1 = 4'($urandom);
        bus.fill1 = 1'($urandom);
        bus.req1  = 1'($urandom);
      end else if (!bus.req1) begin
        bus.data1 = 4'($urandom);
        bus.fill1 = 1'($urandom);
        bus.req1  = ($urandom_range(0, 3) == 0);
      end
    end
    rst = 1'b0;
    chk("done_total", d_done_n, m_done_n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/shift_sched.md
Name: shift_sched

Overview:
- Two-requester scheduler that shares one 4-bit parallel-load shift register between two clients.
- Arbitrates requests round-robin and accepts a parallel word from the winner.
- Drives the register's load, parallel-data and serial-input controls through a load-then-shift sequence of fixed length.
- Reports completion to the winning requester; sits between client logic and the shift-register datapath in the lab's final-project design.

Parameters:
- WIDTH, 4, shift-register width and number of shift cycles per transaction.
- CNT_W, 3, width of shift_cnt; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- req0  in  1  requester 0 request, level; held until ack0.
- req1  in  1  requester 1 request, level; held until ack1.
- data0  in  WIDTH  requester 0 parallel word; stable while req0=1.
- data1  in  WIDTH  requester 1 parallel word; stable while req1=1.
- fill0  in  1  serial fill bit for requester 0 transactions.
- fill1  in  1  serial fill bit for requester 1 transactions.
- ack0  out  1  one-cycle accept pulse to requester 0.
- ack1  out  1  one-cycle accept pulse to requester 1.
- sr_load  out  1  shift-register Load control (1 = parallel load, 0 = shift).
- sr_data  out  WIDTH  shift-register parallel input L.
- sr_inp  out  1  shift-register serial input.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- done_id  out  1  requester index for the transaction; valid while done=1.
- shift_cnt  out  CNT_W  shifts completed in the current transaction.

Behaviour:
- Reset: rst sampled at posedge clk.
  - All outputs go to 0 and state goes to IDLE.
  - Round-robin pointer last_grant=1, so requester 0 wins the first tie.
  - rst mid-transaction aborts immediately: no done, no further ack, next cycle is IDLE.
- States: IDLE, LOAD, SHIFT, DONE. All outputs are registered.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester not equal to last_grant.
  - On the granting edge: capture the winner's data into sr_data and its fill bit into a fill register; set gid=winner, last_grant=winner; go to LOAD.
- LOAD (exactly 1 cycle):
  - ack<gid>=1, sr_load=1, sr_data=captured word, busy=1.
  - Then go to SHIFT with shift_cnt=0.
- SHIFT (exactly WIDTH cycles):
  - sr_load=0, sr_inp=captured fill bit; sr_data holds the captured word.
  - shift_cnt increments by 1 each cycle, over 0..WIDTH-1.
  - Leave to DONE when shift_cnt==WIDTH-1.
- DONE (1 cycle):
  - done=1, done_id=gid, sr_load=0, shift_cnt=WIDTH; then go to IDLE.
- Transaction length: WIDTH+2 busy cycles. The earliest next grant is evaluated in the IDLE cycle after DONE, giving WIDTH+3 cycles per back-to-back transaction.
- Requests are never accepted outside IDLE. A req still high in IDLE after its ack is treated as a new request.
- Toggling data or fill after the granting edge has no effect on the current transaction.
- ack0 and ack1 are never high together. done and ack are never high in the same cycle.
- sr_inp is 0 outside SHIFT. sr_data keeps its last value in IDLE (do not care to the datapath).

Optional Feature:
- Macro SHIFT_SCHED_FIXED_PRIO_EN.
- When defined:
  - Arbitration is fixed priority: req0 always beats req1 when both are high.
  - last_grant is not implemented.
- When undefined: round-robin as described above.
- All other timing is identical in both builds.

Test Plan (WIDTH=4):
- Reset hold: rst=1 for 2 cycles with req0=1 -> ack0=0, busy=0, done=0, sr_load=0 throughout; grant occurs on the first edge after rst=0.
- Single request: req0=1, data0=4'b1011, fill0=1 -> next cycle ack0=1, sr_load=1, sr_data=1011; then 4 cycles sr_load=0, sr_inp=1, shift_cnt=0,1,2,3; then done=1, done_id=0; busy high for 6 cycles.
- Contention, round-robin: req0=req1=1 held continuously, data1=4'b0110 -> grants alternate 0,1,0,1; done_id sequence 0,1,0,1; transactions spaced 7 cycles apart.
- Fixed priority (SHIFT_SCHED_FIXED_PRIO_EN defined): req0 and req1 held high -> every grant goes to 0, ack1 never asserts.
- Mid-operation reset: rst=1 for one cycle during SHIFT at shift_cnt=2 -> next cycle IDLE, busy=0, done never pulses for that transaction.
- Data stability: change data0 from 1011 to 0000 in the LOAD cycle -> sr_data stays 1011 through DONE.
